muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//   Multi-cycle sequencer for type-A multiply/divide. Decode issues start with multiDiv;
//   the block runs a 16-iteration shift-add multiply or restoring divide on operand
//   magnitudes, applies sign fixup, and returns a two-register result.
//   It holds the pipeline via stall while busy.
//   It feeds the writeback path selected by regWrite = 2'b11.
// PARAMETERS
//   WIDTH  16  operand width; product/quotient+remainder are 2*WIDTH total
// PORTS
//   clk           in   1        rising-edge clock
//   rst           in   1        synchronous, active-high reset
//   start         in   1        issue request, sampled on rising edge of clk
//   multiDiv      in   2        2'b01 signed multiply, 2'b10 signed divide; 00/11 invalid
//   operand_a     in   WIDTH    multiplicand / dividend (two's complement)
//   operand_b     in   WIDTH    multiplier / divisor (two's complement)
//   busy          out  1        operation in progress (PREP, RUN, FIX)
//   stall         out  1        hold fetch/decode: busy | (start & valid op & state==IDLE/DONE)
//   done          out  1        one-cycle pulse, result_hi/lo valid this cycle and held after
//   result_hi     out  WIDTH    mul: product[2W-1:W]; div: remainder
//   result_lo     out  WIDTH    mul: product[W-1:0];  div: quotient
//   div_by_zero   out  1        divide with operand_b==0; valid with done, held after
// BEHAVIOUR
//   Reset: state=IDLE; busy, stall, done, div_by_zero = 0; result_hi/lo = 0; counter = 0.
//   States: IDLE -> PREP -> RUN -> FIX -> DONE -> IDLE (or PREP on new start).
//   IDLE/DONE: start & valid multiDiv latches op, operands, signs -> PREP. Invalid op ignored.
//   PREP (1 cycle): form |a|, |b| as unsigned WIDTH bits (|0x8000| = 0x8000); clear acc/count.
//   RUN (exactly WIDTH cycles, counter 0..WIDTH-1): mul = shift-add on 2*WIDTH accumulator;
//     div = restoring step, shift remainder, trial subtract, quotient bit = no-borrow.
//   FIX (1 cycle): mul negates product if sign_a^sign_b; div negates quotient if
//     sign_a^sign_b, remainder takes sign of dividend; results registered -> DONE.
//   DONE (1 cycle): done=1, busy=0. All arithmetic wraps modulo 2^WIDTH.
//   Latency: start sampled at edge E -> done high in cycle after edge E+WIDTH+2 (18 for 16).
//   Divide by zero: same fixed latency; result_lo = all ones, result_hi = operand_a,
//     div_by_zero=1. Cleared to 0 by next accepted op.
//   0x8000 / 0xFFFF: quotient 0x8000 (wrap), remainder 0, no flag.
//   start while busy: ignored, operands not re-latched. start in DONE: accepted back-to-back.
//   result_hi/lo change only on the FIX->DONE edge; held otherwise.
//   rst mid-operation: abort to IDLE next edge, outputs to reset values, no done pulse.
//   stall is combinational from start/multiDiv/state. All other outputs registered.
// TESTING
//   7 * -3 -> done at E+18, result_hi=0xFFFF, result_lo=0xFFEB, stall high cycles E..E+17.
//   100 / -7 -> result_lo=0xFFF2 (-14), result_hi=0x0002; -100 / 7 -> 0xFFF2, 0xFFFE.
//   0x04D2 / 0 -> result_lo=0xFFFF, result_hi=0x04D2, div_by_zero=1; next valid op clears flag.
//   0x8000 / 0xFFFF -> 0x8000 / 0x0000; 0x8000 * 0x8000 -> hi=0x4000, lo=0x0000.
//   start pulsed at E+5 with new operands -> ignored, result from first op unchanged.
//   Back-to-back start in DONE cycle -> second done exactly 19 cycles after the first.
//   rst at E+9 -> no done, busy=0, results 0. multiDiv=2'b00 with start -> stays IDLE, stall=0.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// Issue/result bundle between decode and the multiply/divide sequencer.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [1:0]       multiDiv;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;
    logic             div_by_zero;

    // Decode side drives the request and consumes the result.
    modport master (
        output start, multiDiv, operand_a, operand_b,
        input  busy, stall, done, result_hi, result_lo, div_by_zero
    );

    // Sequencer side.
    modport slave (
        input  start, multiDiv, operand_a, operand_b,
        output busy, stall, done, result_hi, result_lo, div_by_zero
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed multiply / restoring divide sequencer.
// Operates on operand magnitudes for WIDTH iterations, then fixes up signs.
module muldiv_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;

    state_t               state_q, state_d;
    logic                 is_div_q;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CW-1:0]        cnt_q;
    logic                 busy_q, done_q, dbz_q;
    logic [WIDTH-1:0]     res_hi_q, res_lo_q;

    logic                 valid_op, accept;
    logic                 sign_a, sign_b, neg_res, b_zero;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH-1:0]     mul_addend;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_rem_sh, div_diff;
    logic                 no_borrow;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo, rem;
    logic [WIDTH-1:0]     fix_hi, fix_lo;

    assign valid_op = (bus.multiDiv == 2'b01) || (bus.multiDiv == 2'b10);
    assign accept   = bus.start && valid_op && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Datapath helpers: magnitudes, one shift-add step, one restoring-divide step, sign fixup.
    always_comb begin
        sign_a     = a_q[WIDTH-1];
        sign_b     = b_q[WIDTH-1];
        neg_res    = sign_a ^ sign_b;
        b_zero     = (b_q == '0);
        mag_a      = sign_a ? (~a_q + 1'b1) : a_q;
        mag_b      = sign_b ? (~b_q + 1'b1) : b_q;
        // Multiply: low half holds the remaining multiplier bits, high half the partial sum.
        mul_addend = acc_q[0] ? mag_a : '0;
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
        mul_next   = {mul_sum, acc_q[WIDTH-1:1]};
        // Divide: high half is the remainder, low half shifts dividend out / quotient in.
        div_rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
        no_borrow  = (div_rem_sh >= {1'b0, mag_b});
        div_diff   = div_rem_sh - {1'b0, mag_b};
        div_next   = {(no_borrow ? div_diff[WIDTH-1:0] : div_rem_sh[WIDTH-1:0]),
                      acc_q[WIDTH-2:0], no_borrow};
        prod_fix   = neg_res ? (~acc_q + 1'b1) : acc_q;
        quo        = acc_q[WIDTH-1:0];
        rem        = acc_q[2*WIDTH-1:WIDTH];
        fix_hi     = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo     = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            if (b_zero) begin
                fix_hi = a_q;
                fix_lo = '1;
            end else begin
                fix_hi = sign_a  ? (~rem + 1'b1) : rem;
                fix_lo = neg_res ? (~quo + 1'b1) : quo;
            end
        end
    end

    // Next-state logic; DONE can accept a new op directly.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: state_d = accept ? S_PREP : S_IDLE;
            S_PREP:         state_d = S_RUN;
            S_RUN:          state_d = (cnt_q == CW'(WIDTH - 1)) ? S_FIX : S_RUN;
            S_FIX:          state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Operand latch, iteration datapath and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_div_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            res_hi_q <= '0;
            res_lo_q <= '0;
        end else begin
            busy_q <= (state_d == S_PREP) || (state_d == S_RUN) || (state_d == S_FIX);
            done_q <= (state_q == S_FIX);
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        is_div_q <= (bus.multiDiv == 2'b10);
                        a_q      <= bus.operand_a;
                        b_q      <= bus.operand_b;
                        dbz_q    <= 1'b0;
                    end
                end
                S_PREP: begin
                    acc_q <= is_div_q ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
                    cnt_q <= '0;
                end
                S_RUN: begin
                    acc_q <= is_div_q ? div_next : mul_next;
                    cnt_q <= cnt_q + 1'b1;
                end
                S_FIX: begin
                    res_hi_q <= fix_hi;
                    res_lo_q <= fix_lo;
                    dbz_q    <= is_div_q && b_zero;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.stall       = busy_q || accept;
    assign bus.done        = done_q;
    assign bus.result_hi   = res_hi_q;
    assign bus.result_lo   = res_lo_q;
    assign bus.div_by_zero = dbz_q;
endmodule
